// File: rtl/cbus_ram_responder.sv
// CBus responder backed by a word-addressed RAM, serving single and burst transfers.
// Optional random ready stalls are compiled in with CBUS_RAM_RANDOM_STALL_EN.

package cbus_pkg;

  localparam logic [1:0] BurstFixed = 2'd0;
  localparam logic [1:0] BurstIncr  = 2'd1;
  localparam logic [1:0] BurstWrap  = 2'd2;

  typedef struct packed {
    logic        valid;
    logic        is_write;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [3:0]  strobe;
    logic [31:0] data;
    logic [3:0]  len;
    logic [1:0]  burst;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [31:0] data;
  } cbus_resp_t;

endpackage

module cbus_ram_responder
  import cbus_pkg::*;
#(
  parameter int unsigned SIZE_WORDS = 4096,
  parameter int unsigned LATENCY    = 2,
  // Image for flow-level memory initialisation; the RAM itself has no load or reset logic.
  parameter string       INIT_FILE  = ""
) (
  input  logic       clk,
  input  logic       reset,
  input  cbus_req_t  creq,
  output cbus_resp_t cresp
);

  localparam int unsigned AW   = $clog2(SIZE_WORDS);
  localparam int unsigned LatW = (LATENCY > 2) ? $clog2(LATENCY) : 1;
  localparam logic [LatW-1:0] LatInit = LatW'((LATENCY > 0) ? (LATENCY - 1) : 0);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StWait  = 2'd1;
  localparam logic [1:0] StBurst = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [LatW-1:0] cnt_lat_q, cnt_lat_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [3:0]      len_q, len_d;
  logic            is_write_q, is_write_d;
  logic [1:0]      burst_q, burst_d;
  logic [AW-1:0]   waddr_q, waddr_d;
  logic [AW-1:0]   waddr_next;
  logic [AW-1:0]   wrap_mask;
  logic            stall;
  logic            beat_fire;

  logic [31:0] mem_q [SIZE_WORDS];

  logic unused_bits;
  assign unused_bits = ^{creq.size, creq.addr[1:0], creq.addr[31:AW+2]};

`ifdef CBUS_RAM_RANDOM_STALL_EN
  // Fibonacci LFSR, taps 16,14,13,11 in right-shift form.
  logic [15:0] lfsr_q, lfsr_d;

  assign lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};

  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr_q <= 16'hACE1;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign stall = (lfsr_q[1:0] == 2'b00);
`else
  assign stall = 1'b0;
`endif

  // Reset in the same cycle suppresses the beat so an aborted burst commits nothing further.
  assign beat_fire = (state_q == StBurst) && creq.valid && !stall && !reset;

  // len+1 is a power of two for WRAP, so len itself is the wrap mask.
  assign wrap_mask = AW'(len_q);

  always_comb begin
    waddr_next = waddr_q;
    unique case (burst_q)
      BurstIncr: waddr_next = waddr_q + AW'(1);
      BurstWrap: waddr_next = (waddr_q & ~wrap_mask) | ((waddr_q + AW'(1)) & wrap_mask);
      default:   waddr_next = waddr_q;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cnt_lat_d  = cnt_lat_q;
    cnt_d      = cnt_q;
    len_d      = len_q;
    is_write_d = is_write_q;
    burst_d    = burst_q;
    waddr_d    = waddr_q;
    unique case (state_q)
      StIdle: begin
        if (creq.valid) begin
          is_write_d = creq.is_write;
          burst_d    = creq.burst;
          len_d      = creq.len;
          waddr_d    = creq.addr[AW+1:2];
          cnt_d      = 4'd0;
          cnt_lat_d  = LatInit;
          state_d    = (LATENCY == 0) ? StBurst : StWait;
        end
      end
      StWait: begin
        if (!creq.valid) begin
          state_d = StIdle;
        end else if (cnt_lat_q == '0) begin
          state_d = StBurst;
        end else begin
          cnt_lat_d = cnt_lat_q - LatW'(1);
        end
      end
      StBurst: begin
        if (!creq.valid) begin
          state_d = StIdle;
        end else if (beat_fire) begin
          if (cnt_q == len_q) begin
            state_d = StIdle;
            cnt_d   = 4'd0;
          end else begin
            cnt_d   = cnt_q + 4'd1;
            waddr_d = waddr_next;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      cnt_lat_q  <= '0;
      cnt_q      <= 4'd0;
      len_q      <= 4'd0;
      is_write_q <= 1'b0;
      burst_q    <= BurstFixed;
      waddr_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_lat_q  <= cnt_lat_d;
      cnt_q      <= cnt_d;
      len_q      <= len_d;
      is_write_q <= is_write_d;
      burst_q    <= burst_d;
      waddr_q    <= waddr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (beat_fire && is_write_q) begin
      for (int b = 0; b < 4; b++) begin
        if (creq.strobe[b]) begin
          mem_q[waddr_q][8*b +: 8] <= creq.data[8*b +: 8];
        end
      end
    end
  end

  always_comb begin
    cresp       = '0;
    cresp.ready = beat_fire;
    cresp.last  = beat_fire && (cnt_q == len_q);
    cresp.data  = beat_fire ? mem_q[waddr_q] : 32'd0;
  end

endmodule
